// File: rtl/aes128_inv_cipher_if.sv
// aes128_inv_cipher_if
//   Handshake and key-fetch bundle for the AES-128 inverse cipher core.
//   in_valid/in_ready/in_data   : ciphertext block in
//   rk_idx/rk_in                : round-key index out, key returned same cycle
//   out_valid/out_ready/out_data: plaintext block out
//   Byte order on all 128-bit fields: byte 0 = [127:120], byte 4c+r = state[r][c].
//   slave  : the cipher core side
//   master : the side feeding ciphertext, round keys and consuming plaintext
interface aes128_inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave  (input  in_valid, in_data, rk_in, out_ready,
                  output in_ready, rk_idx, out_valid, out_data);
  modport master (output in_valid, in_data, rk_in, out_ready,
                  input  in_ready, rk_idx, out_valid, out_data);
endinterface

// File: rtl/aes128_inv_cipher_core.sv
// aes128_inv_cipher_core
//   Iterative AES-128 decryptor: one inverse round per clock, 10 round cycles
//   per block, no overlap between blocks. Round keys are fetched by index
//   from an external key-schedule store that answers combinationally.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : aes128_inv_cipher_if.slave (in/out handshakes, rk_idx/rk_in)
//   Parameter ROUNDS must be 10.

// Inverse S-box lookup (FIPS-197 Fig. 14); entry 0x00 is the leftmost byte.
module aes128_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  // Element 255 holds entry 0x00, so index by the complement.
  assign y = INV_SBOX[~a];
endmodule

module aes128_inv_cipher_core #(
  parameter int ROUNDS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  aes128_inv_cipher_if.slave bus
);
  if (ROUNDS != 10) begin : g_cfg_err
    $error("aes128_inv_cipher_core: ROUNDS must be 10");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic [127:0] blk_q, blk_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  // Packed byte views: element 15-k is byte k.
  logic [15:0][7:0] st, isr, isb, ark, imc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // sel 0..3 -> multiply by 0e, 0b, 0d, 09 from one xtime chain.
  function automatic logic [7:0] imul(input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (sel)
      2'd0:    return x8 ^ x4 ^ x2;
      2'd1:    return x8 ^ x2 ^ b;
      2'd2:    return x8 ^ x4 ^ b;
      default: return x8 ^ b;
    endcase
  endfunction

  assign st = blk_q;

  // InvShiftRows as pure wiring: out(r,c) = in(r,(c-r) mod 4), then InvSubBytes.
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int R = k % 4;
    localparam int C = k / 4;
    localparam int S = 4 * ((C - R + 4) % 4) + R;
    assign isr[15-k] = st[15-S];
    aes128_inv_sbox u_isbox (.a(isr[15-k]), .y(isb[15-k]));
  end

  assign ark = isb ^ bus.rk_in;

  // InvMixColumns: coefficient for (row r, input j) is {0e,0b,0d,09}[(j-r) mod 4].
  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          imc[15-(4*c+r)] = imc[15-(4*c+r)] ^ imul(ark[15-(4*c+j)], 2'((j - r) & 3));
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    rk_idx_d    = rk_idx_q;
    blk_d       = blk_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        blk_d      = bus.in_data ^ bus.rk_in;
        round_d    = 4'd9;
        rk_idx_d   = 4'd9;
        in_ready_d = 1'b0;
        fsm_d      = ROUND;
      end
      ROUND: if (round_q == 4'd0) begin
        blk_d       = ark;
        out_valid_d = 1'b1;
        rk_idx_d    = 4'd0;
        fsm_d       = DONE;
      end else begin
        blk_d    = imc;
        round_d  = round_q - 4'd1;
        rk_idx_d = round_q - 4'd1;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        rk_idx_d    = 4'd10;
        fsm_d       = IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        rk_idx_d    = 4'd10;
        fsm_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      rk_idx_q    <= 4'd10;
      blk_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      rk_idx_q    <= rk_idx_d;
      blk_q       <= blk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = blk_q;
  assign bus.rk_idx    = rk_idx_q;
endmodule

// File: tb/tb_aes128_inv_cipher_core.sv
// Bench for aes128_inv_cipher_core: FIPS-197 known answers, rk_idx order,
// latency, backpressure, back-to-back blocks, mid-operation reset and random
// blocks against a byte-array reference decryptor with its own key schedule.
module tb_aes128_inv_cipher_core;
  logic clk, rst_n;
  aes128_inv_cipher_if bus();

  aes128_inv_cipher_core #(.ROUNDS(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] rks [11];

  always_comb bus.rk_in = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [127:0] k, res;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    k = rks[10];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      k = rks[rnd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = isbox[s[4*((c-r+4)%4)+r]] ^ k[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd == 0) s[4*c+r] = t[4*c+r];
          else begin
            s[4*c+r] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c+r] = s[4*c+r] ^ gm(t[4*c+j], m[(j-r+4)%4]);
          end
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_block(input logic [127:0] ct, input string tag, output logic [3:0] idx0);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    idx0 = bus.rk_idx;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = rnd128();
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(output int lat, inout logic [43:0] seq);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      seq = {seq[39:0], bus.rk_idx};
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                           input string tag, input bit chk_seq);
    int lat;
    logic [3:0]  idx0;
    logic [43:0] seq;
    start_block(ct, tag, idx0);
    seq = {40'h0, idx0};
    wait_done(lat, seq);
    chk({tag, "_lat"}, 128'(lat), 128'(10));
    chk({tag, "_pt"}, bus.out_data, exp);
    if (chk_seq) chk({tag, "_rk_seq"}, 128'(seq), 128'(44'ha9876543210));
    @(negedge clk);
    chk({tag, "_ov_drop"}, 128'(bus.out_valid), 128'(0));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n;
    logic [3:0]   idx0;
    logic [43:0]  seq;
    logic [127:0] held, exp;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    build_sbox();
    set_key(C1_KEY);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    rst_n = 1'b1;

    // Known answers
    run_block(C1_CT, C1_PT, "kat_c1", 1'b0);
    set_key(B_KEY);
    run_block(B_CT, B_PT, "kat_b", 1'b1);

    // Backpressure: hold output 20 cycles, in_valid pulses must be ignored
    set_key(C1_KEY);
    bus.out_ready = 1'b0;
    start_block(C1_CT, "bp", idx0);
    seq = '0;
    wait_done(lat, seq);
    chk("bp_lat", 128'(lat), 128'(10));
    held = bus.out_data;
    chk("bp_pt", held, C1_PT);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'(i & 1);
      bus.in_data  = rnd128();
      @(negedge clk);
      chk("bp_hold_data", bus.out_data, held);
      chk("bp_hold_ov", 128'(bus.out_valid), 128'(1));
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ov", 128'(bus.out_valid), 128'(0));
    chk("bp_rel_in_ready", 128'(bus.in_ready), 128'(1));

    // Back-to-back: in_valid held high across two blocks
    set_key(B_KEY);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = B_CT;
    @(negedge clk);
    bus.in_data = C1_CT;
    seq = '0;
    wait_done(lat, seq);
    chk("b2b_lat0", 128'(lat), 128'(10));
    chk("b2b_pt0", bus.out_data, B_PT);
    set_key(C1_KEY);
    @(negedge clk);
    chk("b2b_gap_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    chk("b2b_accept1", 128'(bus.in_ready), 128'(0));
    bus.in_valid = 1'b0;
    wait_done(lat, seq);
    chk("b2b_lat1", 128'(lat), 128'(10));
    chk("b2b_pt1", bus.out_data, C1_PT);
    @(negedge clk);

    // Reset while round counter is at 4
    start_block(B_CT, "mrst", idx0);
    n = 0;
    while (bus.rk_idx != 4'd4 && n < 20) begin @(negedge clk); n++; end
    chk("mrst_reach_r4", 128'(bus.rk_idx), 128'(4));
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 128'(bus.out_valid), 128'(0));
    chk("mrst_in_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle_idx", 128'(bus.rk_idx), 128'(10));
    run_block(C1_CT, C1_PT, "mrst_c1", 1'b1);

    // Byte-wiring probe and random blocks against the model
    set_key(rnd128());
    run_block(128'h000102030405060708090a0b0c0d0e0f,
              ref_dec(128'h000102030405060708090a0b0c0d0e0f), "isr_probe", 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_key(rnd128());
      held = rnd128();
      exp  = ref_dec(held);
      run_block(held, exp, "rand", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
